// File: rtl/d_flip_flop.sv
// ---------------------------------------------------------------------------
// d_flip_flop
//
// Parameterised positive-edge D-type storage register with true and
// complementary outputs. Intended as a generic state element for datapath
// staging and control-flag retention.
//
// Optional feature macro: DFF_CLOCK_ENABLE_EN
//   When defined, an `en` input is added and a rising edge captures d only
//   when en is high (q holds otherwise). Reset still overrides en.
//   When undefined, every rising edge captures d.
//
// Parameters
//   WIDTH        number of stored bits (>= 1)
//   RESET_VALUE  value forced onto q while rst_n is low
//
// Ports
//   clk    in   1      clock; captures on the rising edge only
//   rst_n  in   1      asynchronous, active-low reset
//   d      in   WIDTH  data to capture
//   en     in   1      capture enable (only with DFF_CLOCK_ENABLE_EN)
//   q      out  WIDTH  stored value
//   qbar   out  WIDTH  bitwise complement of q
// ---------------------------------------------------------------------------
module d_flip_flop #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
`ifdef DFF_CLOCK_ENABLE_EN
  input  logic             en,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] q_reg;
  logic             capture;

`ifdef DFF_CLOCK_ENABLE_EN
  assign capture = en;
`else
  assign capture = 1'b1;
`endif

  // Reset is in the sensitivity list so q takes RESET_VALUE the moment
  // rst_n falls, and the reset branch has priority over a coincident edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= RESET_VALUE;
    end else if (capture) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

  // qbar is built per bit straight from the stored bit rather than from a
  // second register, so q and qbar can never disagree, even in reset.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_qbar
      assign qbar[gi] = ~q_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_d_flip_flop.sv
// ---------------------------------------------------------------------------
// tb_d_flip_flop
//
// Scoreboard bench for d_flip_flop. Two instances run side by side:
//   dut1: WIDTH=1, RESET_VALUE=0
//   dut8: WIDTH=8, RESET_VALUE=8'hA5
// The driver changes inputs at the falling clock edge, updates a simple
// "what the register should hold" model, and queues the expected outputs.
// One monitor pops an entry 2 time units after every rising edge; a second
// monitor pops an entry 1 time unit after every reset assertion to confirm
// the outputs changed without waiting for a clock.
// Build with +define+DFF_CLOCK_ENABLE_EN to exercise the enable variant.
// ---------------------------------------------------------------------------
module tb_d_flip_flop;

  localparam logic       RV1 = 1'b0;
  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       d1;
  logic [7:0] d8;
  logic       q1, qb1;
  logic [7:0] q8, qb8;

  always #5 clk = ~clk;

  d_flip_flop #(.WIDTH(1), .RESET_VALUE(RV1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (d1),
`ifdef DFF_CLOCK_ENABLE_EN
    .en   (en),
`endif
    .q    (q1),
    .qbar (qb1)
  );

  d_flip_flop #(.WIDTH(8), .RESET_VALUE(RV8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (d8),
`ifdef DFF_CLOCK_ENABLE_EN
    .en   (en),
`endif
    .q    (q8),
    .qbar (qb8)
  );

  typedef struct {
    logic       q1;
    logic [7:0] q8;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  // Reference state: what each register is supposed to hold right now.
  logic       m1;
  logic [7:0] m8;

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic compare_entry(input exp_t e);
    cmp({e.tag, ".q1"},    {7'b0, q1},  {7'b0, e.q1});
    cmp({e.tag, ".qbar1"}, {7'b0, qb1}, {7'b0, ~e.q1});
    cmp({e.tag, ".q8"},    q8,  e.q8);
    cmp({e.tag, ".qbar8"}, qb8, ~e.q8);
    $display("check %-8s q1=%b qbar1=%b q8=%h qbar8=%h (exp q1=%b q8=%h)",
             e.tag, q1, qb1, q8, qb8, e.q1, e.q8);
  endtask

  // Edge monitor: one expected state per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() != 0) compare_entry(sb.pop_front());
    end
  end

  // Reset monitor: outputs must already show the reset value 1 unit after
  // rst_n falls, long before the next rising edge.
  initial begin
    #1;
    forever begin
      @(negedge rst_n);
      #1;
      if (sb.size() == 0) cmp("async_entry_missing", 8'h00, 8'h01);
      else compare_entry(sb.pop_front());
    end
  end

  // Drive one cycle's worth of inputs, then wait for the next falling edge.
  // glitch: d is first driven to the opposite value and only settles on the
  // final value 2 units later, still well before the rising edge.
  task automatic drive_cycle(input logic r, input logic a, input logic [7:0] b,
                             input logic e, input bit glitch, input string tag);
    logic was_high;
    logic eff_en;
    exp_t ent;
    was_high = (rst_n === 1'b1);
    eff_en   = 1'b1;
`ifdef DFF_CLOCK_ENABLE_EN
    eff_en   = e;
`endif
    rst_n = r;
    en    = e;
    if (!r) begin
      m1 = RV1;
      m8 = RV8;
      if (was_high) begin
        ent = '{q1: m1, q8: m8, tag: {tag, "_now"}};
        sb.push_back(ent);
      end
    end
    if (glitch) begin
      d1 = ~a;
      d8 = ~b;
      #2;
    end
    d1 = a;
    d8 = b;
    if (r && eff_en) begin
      m1 = a;
      m8 = b;
    end
    ent = '{q1: m1, q8: m8, tag: tag};
    sb.push_back(ent);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    d1    = 1'b0;
    d8    = 8'h00;
    m1    = RV1;
    m8    = RV8;

    // Reset window with data and enable wiggling: outputs stay at reset.
    for (int i = 0; i < 4; i++)
      drive_cycle(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'b0, "reset");

    // Release and walk d through 0,1,0,1 (and four byte patterns).
    drive_cycle(1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, "d0");
    drive_cycle(1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, "d1");
    drive_cycle(1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, "d2");
    drive_cycle(1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, "d3");

    // Mid-cycle pulses on d that are gone by the edge must not be captured.
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, "glitch0");
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, "glitch1");

    // Asynchronous reset mid-cycle while q holds 1 / a non-reset byte.
    drive_cycle(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, "pre_rst");
    #2;
    drive_cycle(1'b0, 1'b1, 8'h77, 1'b1, 1'b0, "async");
    drive_cycle(1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, "release");

`ifdef DFF_CLOCK_ENABLE_EN
    // Enable low holds q for three edges; raising it captures on the next.
    drive_cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "en_zero");
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, "en_hold");
    drive_cycle(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, "en_cap");
`endif

    // Randomized traffic with occasional resets (edge-aligned and mid-cycle).
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        #2;
        drive_cycle(1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'b0, "rnd_arst");
      end else begin
        drive_cycle(($urandom_range(0, 11) != 0), 1'($urandom), 8'($urandom),
                    1'($urandom), 1'($urandom), "rnd");
      end
    end

    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cmp("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
